// File: rtl/sonic_gb_pkg.sv
// Shared types and constants for the SONIC gearbox read controller.
// The idle block is a control block (sync header 2'b10) with block type
// 0x1E and all-zero idle characters, sent whenever the FIFO runs dry.
package sonic_gb_pkg;

  localparam int BLOCK_W = 66;

  localparam logic [BLOCK_W-1:0] SONIC_IDLE_BLOCK = {56'h0, 8'h1E, 2'b10};

  // Controller states: gearbox held off in IDLE/PRIME, fed only in RUN.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } fsm_t;

  // Per-request decision made at issue time and carried to the landing stage.
  typedef enum logic {
    FETCH = 1'b0,
    SUBST = 1'b1
  } tag_t;

endpackage

// File: rtl/sonic_delay_line.sv
// Fixed-depth shift register used to age read requests toward the gearbox
// capture point. A synchronous flush empties every stage at once so that
// requests in flight can be abandoned when the controller is disabled.
// DEPTH of zero degenerates to a wire.
module sonic_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] entry,
  output logic [W-1:0] tail
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign tail = entry;
    end else begin : g_shift
      logic [W-1:0] stage [DEPTH];

      // Advance one stage per clock; flush or reset clears the whole line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (flush) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= entry;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign tail = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sonic_gearbox_rd_ctrl.sv
// Read sequencer between the TX 66-bit block FIFO and the 66->40 gearbox.
// Each gearbox read request is aged so that the FIFO is read early enough
// for its data to reach gb_data exactly RD_LATENCY cycles after the
// request. If the FIFO is empty at issue time an idle block is substituted
// instead, keeping the gearbox fed. Statistics feed the register file.
module sonic_gearbox_rd_ctrl
  import sonic_gb_pkg::*;
#(
  parameter int                 RD_LATENCY   = 5,
  parameter int                 FIFO_LAT     = 1,
  parameter int                 USEDW_W      = 9,
  parameter int                 START_THRESH = 16,
  parameter logic [BLOCK_W-1:0] IDLE_BLOCK   = SONIC_IDLE_BLOCK
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clr_stats,
  input  logic               gb_rd_req,
  output logic               gb_ena,
  output logic [BLOCK_W-1:0] gb_data,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [BLOCK_W-1:0] fifo_q,
  output logic               fifo_rdreq,
  output logic               underflow,
  output logic               underflow_sticky,
  output logic [31:0]        blk_cnt,
  output logic [15:0]        uflow_cnt
);

  // Stage (counted in cycles after the request) where the FIFO is read,
  // chosen so the FIFO output is valid one cycle before gb_data updates.
  localparam int ISSUE = RD_LATENCY - FIFO_LAT - 1;

  localparam logic [USEDW_W-1:0] THRESH = USEDW_W'(START_THRESH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fsm_t       state;
  logic       run;
  logic       flush;
  logic       accept;
  logic       issue_vld;
  tag_t       issue_tag;
  logic [1:0] land_bits;
  logic       land_vld;
  tag_t       land_tag;
  logic       land_fetch;
  logic       land_subst;

  assign run    = (state == RUN);
  // Dropping enable abandons everything in flight, including the read
  // decision being made in the same cycle.
  assign flush  = ~enable;
  assign accept = gb_rd_req & run;

  // Control FSM; gb_ena is registered with the state so it tracks RUN exactly.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      gb_ena <= 1'b0;
    end else if (!enable) begin
      state  <= IDLE;
      gb_ena <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= PRIME;
        end
        PRIME: begin
          if (fifo_usedw >= THRESH) begin
            state  <= RUN;
            gb_ena <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state  <= IDLE;
          gb_ena <= 1'b0;
        end
      endcase
    end
  end

  // ---- request aging: accept -> issue stage ----
  sonic_delay_line #(
    .W     (1),
    .DEPTH (ISSUE)
  ) u_issue_line (
    .clk   (clk_in),
    .rst_n (reset_n),
    .flush (flush),
    .entry (accept),
    .tail  (issue_vld)
  );

  // ---- issue stage: decide FIFO read or idle substitution ----
  assign issue_tag  = fifo_empty ? SUBST : FETCH;
  assign fifo_rdreq = issue_vld & ~fifo_empty & enable;

  sonic_delay_line #(
    .W     (2),
    .DEPTH (FIFO_LAT)
  ) u_land_line (
    .clk   (clk_in),
    .rst_n (reset_n),
    .flush (flush),
    .entry ({issue_vld, issue_tag}),
    .tail  (land_bits)
  );

  // ---- landing stage: FIFO data valid, capture into gb_data ----
  assign land_vld   = land_bits[1] & enable;
  assign land_tag   = tag_t'(land_bits[0]);
  assign land_fetch = land_vld & (land_tag == FETCH);
  assign land_subst = land_vld & (land_tag == SUBST);

  // Gearbox data register; holds its value between landings.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      gb_data <= IDLE_BLOCK;
    end else if (land_fetch) begin
      gb_data <= fifo_q;
    end else if (land_subst) begin
      gb_data <= IDLE_BLOCK;
    end
  end

  // Statistics; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      underflow        <= 1'b0;
      underflow_sticky <= 1'b0;
      blk_cnt          <= 32'd0;
      uflow_cnt        <= 16'd0;
    end else begin
      underflow <= land_subst;
      if (clr_stats) begin
        underflow_sticky <= 1'b0;
        blk_cnt          <= 32'd0;
        uflow_cnt        <= 16'd0;
      end else begin
        if (land_fetch) begin
          blk_cnt <= blk_cnt + 32'd1;
        end
        if (land_subst) begin
          uflow_cnt        <= sat_inc(uflow_cnt);
          underflow_sticky <= 1'b1;
        end
      end
    end
  end

endmodule
